// File: rtl/regfile_dbg_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_dbg_arbiter_if
// Debug-side bus of the register-file debug arbiter.
// Signal names are given from the arbiter's point of view (_i into the
// arbiter, _o out of it).
//   dbg_halt_i    level request to halt the pipeline
//   dbg_req_i     4-phase access request, held until ack
//   dbg_we_i      1 = write, 0 = read, valid with req
//   dbg_addr_i    register id
//   dbg_wdata_i   write data
//   dbg_ack_o     access done, held until req drops
//   dbg_rdata_o   read data, valid while ack
//   dbg_err_o     access rejected (only with RFARB_RSP_PROTECT_EN)
//   dbg_halted_o  pipeline halted and register file owned by debug
// Modports: master = debug requester, slave = arbiter.
// ---------------------------------------------------------------------------
interface regfile_dbg_arbiter_if;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 64;

    logic              dbg_halt_i;
    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ID_W-1:0]   dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_ack_o;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic              dbg_err_o;
    logic              dbg_halted_o;

    modport master (
        output dbg_halt_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_ack_o, dbg_rdata_o, dbg_err_o, dbg_halted_o
    );

    modport slave (
        input  dbg_halt_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_ack_o, dbg_rdata_o, dbg_err_o, dbg_halted_o
    );
endinterface

// File: rtl/regfile_dbg_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_dbg_arbiter
// Shares register-file read port A and write port E between the Y86
// pipeline (decode read / writeback write) and an external debug port.
// A debug halt freezes the pipeline, waits DRAIN_CYCLES for in-flight
// instructions to retire, then hands the register file to single-word
// 4-phase debug accesses.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   dbg (slave modport)      debug halt / access handshake bus
//   pipe_freeze_o            stall F and D, bubble E (registered)
//   pipe_srcA_i/dstE_i/valE_i  pipeline side of ports A and E
//   rf_srcA_o/dstE_o/valE_o  register-file side (combinational mux)
//   rf_rvalA_i               register-file read data A
// Optional feature macro: RFARB_RSP_PROTECT_EN
//   When defined, debug writes to %rsp (id 4) are suppressed and flagged
//   on dbg_err_o for the ACK phase; otherwise dbg_err_o is tied 0.
// ---------------------------------------------------------------------------
module regfile_dbg_arbiter #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [3:0]  RNONE_ID     = 4'hF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    regfile_dbg_arbiter_if.slave dbg,
    output logic        pipe_freeze_o,
    input  logic [3:0]  pipe_srcA_i,
    input  logic [3:0]  pipe_dstE_i,
    input  logic [63:0] pipe_valE_i,
    output logic [3:0]  rf_srcA_o,
    output logic [3:0]  rf_dstE_o,
    output logic [63:0] rf_valE_o,
    input  logic [63:0] rf_rvalA_i
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 64;
`ifdef RFARB_RSP_PROTECT_EN
    localparam logic [3:0] RSP_ID = 4'd4;
`endif

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_ACCESS,
        ST_ACK
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                freeze_q, freeze_d;
    logic                halted_q, halted_d;
    logic                wr_hit_c;

`ifdef RFARB_RSP_PROTECT_EN
    logic                err_q, err_d;
    // Debug write that lands on %rsp is rejected
    assign wr_hit_c = dbg.dbg_we_i && (dbg.dbg_addr_i != RSP_ID);
`else
    assign wr_hit_c = dbg.dbg_we_i;
`endif

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            freeze_q <= 1'b0;
            halted_q <= 1'b0;
`ifdef RFARB_RSP_PROTECT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            freeze_q <= freeze_d;
            halted_q <= halted_d;
`ifdef RFARB_RSP_PROTECT_EN
            err_q    <= err_d;
`endif
        end
    end

    // Next state, next registered outputs and register-file port mux
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rf_srcA_o = pipe_srcA_i;
        rf_dstE_o = pipe_dstE_i;
        rf_valE_o = pipe_valE_i;

        unique case (state_q)
            ST_RUN: begin
                if (dbg.dbg_halt_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                // A halt drop mid-drain still runs the full drain
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = dbg.dbg_halt_i ? ST_HALTED : ST_RUN;
                end
            end
            ST_HALTED: begin
                if (dbg.dbg_req_i) begin
                    state_d = ST_ACCESS;
                end else if (!dbg.dbg_halt_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_ACCESS: begin
                state_d = ST_ACK;
                // Reset wins so no debug write lands on the reset edge
                if (!rst_i) begin
                    rf_srcA_o = dbg.dbg_addr_i;
                    rf_dstE_o = wr_hit_c ? dbg.dbg_addr_i : RNONE_ID;
                    rf_valE_o = dbg.dbg_wdata_i;
                end
                if (!dbg.dbg_we_i) begin
                    rdata_d = (dbg.dbg_addr_i == RNONE_ID) ? '0 : rf_rvalA_i;
                end
            end
            ST_ACK: begin
                if (!dbg.dbg_req_i) begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        ack_d    = (state_d == ST_ACK);
        freeze_d = (state_d != ST_RUN);
        halted_d = (state_d == ST_HALTED) || (state_d == ST_ACCESS) ||
                   (state_d == ST_ACK);
`ifdef RFARB_RSP_PROTECT_EN
        // Latched on entry to ACK, held for the whole ACK phase
        err_d = 1'b0;
        if (state_d == ST_ACK) begin
            err_d = (state_q == ST_ACCESS) ? (dbg.dbg_we_i && !wr_hit_c) : err_q;
        end
`endif
    end

    assign dbg.dbg_ack_o    = ack_q;
    assign dbg.dbg_rdata_o  = rdata_q;
    assign dbg.dbg_halted_o = halted_q;
    assign pipe_freeze_o    = freeze_q;
`ifdef RFARB_RSP_PROTECT_EN
    assign dbg.dbg_err_o    = err_q;
`else
    assign dbg.dbg_err_o    = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_dbg_arbiter
// Randomized self-checking bench. A register-file array sits behind the rf_*
// ports; an abstract model (expected register contents plus last read value)
// predicts each debug response, which is queued and checked by a separate
// monitor when ack rises. Honours RFARB_RSP_PROTECT_EN.
// ---------------------------------------------------------------------------
module tb_regfile_dbg_arbiter;
    localparam int unsigned DC    = 3;
    localparam logic [3:0]  RNONE = 4'hF;
`ifdef RFARB_RSP_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_freeze;
    logic [3:0]  pipe_srcA, pipe_dstE;
    logic [63:0] pipe_valE;
    logic [3:0]  rf_srcA, rf_dstE;
    logic [63:0] rf_valE, rf_rvalA;
    logic        mem_clr;
    int          cyc = 0;

    always #5 clk = ~clk;

    regfile_dbg_arbiter_if dbg_if ();

    regfile_dbg_arbiter #(.DRAIN_CYCLES(DC), .RNONE_ID(RNONE)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .dbg          (dbg_if),
        .pipe_freeze_o(pipe_freeze),
        .pipe_srcA_i  (pipe_srcA),
        .pipe_dstE_i  (pipe_dstE),
        .pipe_valE_i  (pipe_valE),
        .rf_srcA_o    (rf_srcA),
        .rf_dstE_o    (rf_dstE),
        .rf_valE_o    (rf_valE),
        .rf_rvalA_i   (rf_rvalA)
    );

    // Register file behind the arbiter
    logic [63:0] rf_mem [16];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
        end else if (rf_dstE != RNONE) begin
            rf_mem[rf_dstE] <= rf_valE;
        end
    end
    assign rf_rvalA = (rf_srcA == RNONE) ? 64'd0 : rf_mem[rf_srcA];

    // Reference model and scoreboard
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          ack_cyc;
    } exp_t;
    exp_t        sb_q [$];
    logic [63:0] exp_regs [16];
    logic [63:0] last_rd;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pipeline cycle in RUN: random traffic must pass straight through
    task automatic run_cycle();
        pipe_srcA = 4'($urandom_range(0, 15));
        pipe_dstE = 4'($urandom_range(0, 15));
        pipe_valE = {$urandom, $urandom};
        #1;
        chk("run_srcA", 64'(rf_srcA), 64'(pipe_srcA));
        chk("run_dstE", 64'(rf_dstE), 64'(pipe_dstE));
        chk("run_valE", rf_valE, pipe_valE);
        if (pipe_dstE != RNONE) exp_regs[pipe_dstE] = pipe_valE;
        tick();
        pipe_dstE = RNONE;
        pipe_valE = '0;
    endtask

    task automatic halt_and_wait();
        int n;
        dbg_if.dbg_halt_i = 1'b1;
        n = 0;
        while (!dbg_if.dbg_halted_o && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("halt_timeout", 64'(n), 64'(DC + 1));
    endtask

    // Full 4-phase debug access; expected response goes to the scoreboard
    task automatic access(input logic we, input logic [3:0] addr, input logic [63:0] data);
        exp_t e;
        logic effective;
        int   n;
        effective = we && (addr != RNONE) && !(PROTECT && addr == 4'd4);
        if (!we) last_rd = (addr == RNONE) ? 64'd0 : exp_regs[addr];
        if (effective) exp_regs[addr] = data;
        e.rdata   = last_rd;
        e.err     = PROTECT && we && (addr == 4'd4);
        e.ack_cyc = cyc + 2;
        sb_q.push_back(e);
        dbg_if.dbg_we_i    = we;
        dbg_if.dbg_addr_i  = addr;
        dbg_if.dbg_wdata_i = data;
        dbg_if.dbg_req_i   = 1'b1;
        tick();
        // Now in ACCESS: register file is driven by the debug port
        chk("acc_srcA", 64'(rf_srcA), 64'(addr));
        chk("acc_dstE", 64'(rf_dstE), effective ? 64'(addr) : 64'(RNONE));
        if (effective) chk("acc_valE", rf_valE, data);
        n = 0;
        while (!dbg_if.dbg_ack_o && n < 10) begin
            tick();
            n++;
        end
        if (n == 10) chk("ack_timeout", 64'(dbg_if.dbg_ack_o), 64'd1);
        dbg_if.dbg_req_i = 1'b0;
        tick();
        chk("ack_drop", 64'(dbg_if.dbg_ack_o), 64'd0);
        chk("err_drop", 64'(dbg_if.dbg_err_o), 64'd0);
        chk("halted_after", 64'(dbg_if.dbg_halted_o), 64'd1);
        chk("rdata_hold", dbg_if.dbg_rdata_o, last_rd);
    endtask

    // Monitor: compare each rising ack against the oldest expectation
    initial begin
        logic ack_prev;
        exp_t e;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (dbg_if.dbg_ack_o && !ack_prev) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("mon_rdata", dbg_if.dbg_rdata_o, e.rdata);
                    chk("mon_err", 64'(dbg_if.dbg_err_o), 64'(e.err));
                    chk("mon_latency", 64'(cyc), 64'(e.ack_cyc));
                    chk("mon_halted", 64'(dbg_if.dbg_halted_o), 64'd1);
                end
            end
            ack_prev = dbg_if.dbg_ack_o;
        end
    end

    // Stimulus
    initial begin
        logic [63:0] old4, old6;
        rst = 1'b1;
        mem_clr = 1'b1;
        dbg_if.dbg_halt_i  = 1'b0;
        dbg_if.dbg_req_i   = 1'b0;
        dbg_if.dbg_we_i    = 1'b0;
        dbg_if.dbg_addr_i  = '0;
        dbg_if.dbg_wdata_i = '0;
        pipe_srcA = '0;
        pipe_dstE = RNONE;
        pipe_valE = '0;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        last_rd = '0;
        tick();
        tick();
        rst = 1'b0;
        mem_clr = 1'b0;
        chk("rst_ack", 64'(dbg_if.dbg_ack_o), 64'd0);
        chk("rst_rdata", dbg_if.dbg_rdata_o, 64'd0);
        chk("rst_err", 64'(dbg_if.dbg_err_o), 64'd0);
        chk("rst_freeze", 64'(pipe_freeze), 64'd0);
        chk("rst_halted", 64'(dbg_if.dbg_halted_o), 64'd0);

        // Directed pass-through
        pipe_srcA = 4'd3; pipe_dstE = 4'd2; pipe_valE = 64'h55;
        #1;
        chk("pt_srcA", 64'(rf_srcA), 64'd3);
        chk("pt_dstE", 64'(rf_dstE), 64'd2);
        chk("pt_valE", rf_valE, 64'h55);
        exp_regs[2] = 64'h55;
        tick();
        pipe_dstE = RNONE;
        for (int i = 0; i < 6; i++) run_cycle();

        // Halt drain timing: freeze from cycle 1, halted from cycle DC+1
        dbg_if.dbg_halt_i = 1'b1;
        for (int i = 1; i <= DC + 2; i++) begin
            tick();
            chk("drain_freeze", 64'(pipe_freeze), 64'd1);
            chk("drain_halted", 64'(dbg_if.dbg_halted_o), (i >= DC + 1) ? 64'd1 : 64'd0);
        end

        // Directed write/read and RNONE read
        access(1'b1, 4'd5, 64'hDEADBEEF);
        access(1'b0, 4'd5, 64'd0);
        access(1'b0, 4'hF, 64'd0);
        access(1'b0, 4'd2, 64'd0);
        access(1'b1, 4'hF, 64'h1111);

        // %rsp write, then read back
        old4 = exp_regs[4];
        access(1'b1, 4'd4, 64'h99);
        access(1'b0, 4'd4, 64'd0);
        chk("rsp_read", last_rd, PROTECT ? old4 : 64'h99);

        // Randomized accesses interleaved with running phases
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       {$urandom, $urandom});
            end
            dbg_if.dbg_halt_i = 1'b0;
            tick();
            tick();
            chk("resume_freeze", 64'(pipe_freeze), 64'd0);
            for (int i = 0; i < 4; i++) run_cycle();
            halt_and_wait();
        end

        // Request and halt drop in the same HALTED cycle: request wins
        dbg_if.dbg_halt_i = 1'b0;
        access(1'b0, 4'd5, 64'd0);
        tick();
        chk("post_req_freeze", 64'(pipe_freeze), 64'd0);
        chk("post_req_halted", 64'(dbg_if.dbg_halted_o), 64'd0);

        // Halt pulse: full drain, then RUN without halted
        dbg_if.dbg_halt_i = 1'b1;
        tick();
        dbg_if.dbg_halt_i = 1'b0;
        chk("pulse_freeze1", 64'(pipe_freeze), 64'd1);
        for (int i = 2; i <= DC + 1; i++) begin
            tick();
            chk("pulse_freeze", 64'(pipe_freeze), (i <= DC) ? 64'd1 : 64'd0);
            chk("pulse_halted", 64'(dbg_if.dbg_halted_o), 64'd0);
        end

        // Reset during a debug write to reg 6
        halt_and_wait();
        old6 = exp_regs[6];
        dbg_if.dbg_we_i    = 1'b1;
        dbg_if.dbg_addr_i  = 4'd6;
        dbg_if.dbg_wdata_i = 64'h1234;
        dbg_if.dbg_req_i   = 1'b1;
        tick();
        rst = 1'b1;
        pipe_srcA = 4'd1; pipe_dstE = 4'd2; pipe_valE = 64'h77;
        #1;
        chk("rstacc_dstE", 64'(rf_dstE), 64'd2);
        chk("rstacc_valE", rf_valE, 64'h77);
        chk("rstacc_srcA", 64'(rf_srcA), 64'd1);
        exp_regs[2] = 64'h77;
        tick();
        pipe_dstE = RNONE;
        dbg_if.dbg_req_i  = 1'b0;
        dbg_if.dbg_halt_i = 1'b0;
        chk("rstacc_reg6", rf_mem[6], old6);
        chk("rstacc_ack", 64'(dbg_if.dbg_ack_o), 64'd0);
        chk("rstacc_freeze", 64'(pipe_freeze), 64'd0);
        chk("rstacc_halted", 64'(dbg_if.dbg_halted_o), 64'd0);
        rst = 1'b0;
        last_rd = '0;
        tick();
        chk("rstacc_run", 64'(pipe_freeze), 64'd0);
        run_cycle();

        // Final register-file contents and drained scoreboard
        tick();
        for (int i = 0; i < 15; i++) chk("final_reg", rf_mem[i], exp_regs[i]);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_dbg_arbiter.md
Name: regfile_dbg_arbiter

Overview:
- Shares the Y86 register file's read port A and write port E between the pipeline (decode read, writeback write) and an external debug requester.
- On a debug halt request it freezes fetch/decode and bubbles execute. It then waits a fixed drain time for in-flight instructions to retire and grants the register file to the debug port.
- Single-word read/write accesses use a 4-phase handshake.
- Sits between the decode/writeback stages and the register file; all pipeline traffic passes through unchanged while running.

Parameters:
DRAIN_CYCLES, 3, cycles spent in DRAIN after freeze (E, M, W stages); legal range 1..15
RNONE_ID, 4'hF, register id meaning "no register"

Ports:
clk_i  in  1  clock, all state updates on posedge
rst_i  in  1  synchronous reset, active-high
dbg_halt_i  in  1  level; request pipeline halt
dbg_req_i  in  1  access request, 4-phase, held until ack
dbg_we_i  in  1  1=write, 0=read; valid with req
dbg_addr_i  in  4  register id
dbg_wdata_i  in  64  write data
dbg_ack_o  out  1  access done; held until req drops
dbg_rdata_o  out  64  read data, valid while ack
dbg_err_o  out  1  access rejected (optional feature only)
dbg_halted_o  out  1  high in HALTED/ACCESS/ACK
pipe_freeze_o  out  1  stall F and D, bubble E
pipe_srcA_i  in  4  decode srcA
pipe_dstE_i  in  4  writeback dstE
pipe_valE_i  in  64  writeback valE
rf_srcA_o  out  4  to register file srcA
rf_dstE_o  out  4  to register file dstE
rf_valE_o  out  64  to register file valE
rf_rvalA_i  in  64  register file read data A (combinational)

Behaviour:
- States: RUN, DRAIN, HALTED, ACCESS, ACK. Reset: RUN, drain counter 0, dbg_ack_o=0, dbg_rdata_o=0, dbg_err_o=0, pipe_freeze_o=0, dbg_halted_o=0.
- Port mux is combinational:
  - RUN/DRAIN/HALTED/ACK: rf_* = pipe_* pass-through.
  - ACCESS: rf_srcA_o = dbg_addr_i. If we=1: rf_dstE_o = dbg_addr_i, rf_valE_o = dbg_wdata_i. If we=0: rf_dstE_o = RNONE_ID.
  - rst_i high forces pass-through in every state, so no debug write lands on the reset edge.
- pipe_freeze_o=1 in every state except RUN.
- RUN: dbg_halt_i=1 -> DRAIN, counter cleared.
- DRAIN: counter increments every cycle; at counter == DRAIN_CYCLES-1 -> HALTED if dbg_halt_i=1, else RUN. Halt drop mid-drain does not abort the drain.
- HALTED:
  - dbg_req_i=1 -> ACCESS. Request has priority over a simultaneous halt drop.
  - Otherwise dbg_halt_i=0 -> RUN.
  - dbg_req_i outside HALTED is ignored (held pending).
- ACCESS: exactly 1 cycle.
  - Write: committed at the ACCESS->ACK edge.
  - Read: dbg_rdata_o <= rf_rvalA_i at the same edge. Address RNONE_ID reads as 0.
  - Write to RNONE_ID: dropped, ack still given.
  - -> ACK.
- ACK: dbg_ack_o=1. Stay until dbg_req_i=0, then -> HALTED and ack drops that edge. dbg_rdata_o holds its value until the next read.
- Latency: req seen in HALTED -> ack high 2 cycles later.
- Halt -> dbg_halted_o latency: DRAIN_CYCLES+1 cycles.
- Changing dbg_we_i, dbg_addr_i or dbg_wdata_i while req is high is illegal.
- Reset in any state returns to RUN next cycle with freeze released.

Optional Feature:
RFARB_RSP_PROTECT_EN
- Defined: debug write to register 4 (%rsp) is suppressed in ACCESS (rf_dstE_o = RNONE_ID). dbg_err_o=1 for the whole ACK phase. Reads of %rsp are allowed.
- Undefined: %rsp is writable like any other register. dbg_err_o is tied 0.

Test Plan:
- RUN pass-through: pipe_srcA_i=3, pipe_dstE_i=2, pipe_valE_i=0x55 -> rf_srcA_o=3, rf_dstE_o=2, rf_valE_o=0x55; freeze=0.
- Halt drain: dbg_halt_i=1 at cycle 0, DRAIN_CYCLES=3 -> freeze=1 from cycle 1; dbg_halted_o=1 from cycle 4.
- Write then read: in HALTED, write reg 5 = 0xDEADBEEF, full handshake; then read reg 5 -> dbg_rdata_o=0xDEADBEEF with ack. Then read reg 0xF -> 0.
- Simultaneous events:
  - In HALTED, req=1 and halt=0 same cycle -> ACCESS taken.
  - After ack and req drop, halt=0 -> RUN, freeze=0.
  - Halt drop in DRAIN -> full drain, then RUN without dbg_halted_o.
- Reset mid-access: rst_i=1 during ACCESS with write reg 6 = 0x1234 -> rf_dstE_o follows pipe_dstE_i that cycle; reg 6 unchanged; state RUN, ack=0, freeze=0.
- With RFARB_RSP_PROTECT_EN: write reg 4 = 0x99 -> dbg_err_o=1 with ack; subsequent read of reg 4 returns the old value. Without the macro -> reads 0x99, err=0.
